// File: rtl/flow_distributor_n_if.sv
// flow_distributor_n_if: block-stream input and round-stream output bundle of the distributor
interface flow_distributor_n_if #(
    parameter int BITS_BLOCK = 257,
    parameter int NUM_FLOWS  = 2,
    parameter int CNT_W      = 12
);
    logic                            i_valid;
    logic                            i_sync;
    logic [BITS_BLOCK-1:0]           input_blocks;
    logic                            o_ready;
    logic [NUM_FLOWS*BITS_BLOCK-1:0] flows;
    logic                            valid;
    logic                            i_ready;
    logic                            o_am_round;
    logic [CNT_W-1:0]                o_round_cnt;
    logic                            o_partial_err;

    modport slave (
        input  i_valid, i_sync, input_blocks, i_ready,
        output o_ready, flows, valid, o_am_round, o_round_cnt, o_partial_err
    );

    modport master (
        output i_valid, i_sync, input_blocks, i_ready,
        input  o_ready, flows, valid, o_am_round, o_round_cnt, o_partial_err
    );
endinterface

// File: rtl/flow_distributor_n.sv
// flow_distributor_n: round-robin dealer of blocks to NUM_FLOWS flows with AM round tracking
module flow_distributor_n #(
    parameter int BITS_BLOCK    = 257,
    parameter int NUM_FLOWS     = 2,
    parameter int ROUNDS_PER_AM = 4096,
    parameter int CNT_W         = (ROUNDS_PER_AM > 1) ? $clog2(ROUNDS_PER_AM) : 1
) (
    input logic                clk,
    input logic                rst,
    flow_distributor_n_if.slave bus
);
    localparam int PTR_W  = $clog2(NUM_FLOWS);
    localparam int BANK_W = (NUM_FLOWS - 1) * BITS_BLOCK;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_FLOWS - 1);
    localparam logic [CNT_W-1:0] RMAX = CNT_W'(ROUNDS_PER_AM - 1);

    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [BANK_W-1:0]               bank_q, bank_d;
    logic [NUM_FLOWS*BITS_BLOCK-1:0] flows_q, flows_d;
    logic                            valid_q, valid_d;
    logic [CNT_W-1:0]                rcnt_q, rcnt_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            am_q, am_d;
    logic                            perr_q, perr_d;
    logic                            ready, accept, complete, discard;

    // Handshake decode and next-state: a sync block always restarts at slot 0, the last slot bypasses the bank
    always_comb begin
        ready    = !(ptr_q == LAST && valid_q && !bus.i_ready && !(bus.i_valid && bus.i_sync));
        accept   = bus.i_valid && ready;
        complete = accept && !bus.i_sync && ptr_q == LAST;
        discard  = accept && bus.i_sync && ptr_q != '0;
        ptr_d    = ptr_q;
        bank_d   = bank_q;
        if (accept && bus.i_sync) begin
            bank_d[BITS_BLOCK-1:0] = bus.input_blocks;
            ptr_d = PTR_W'(1);
        end else if (complete) begin
            ptr_d = '0;
        end else if (accept) begin
            bank_d[ptr_q*BITS_BLOCK +: BITS_BLOCK] = bus.input_blocks;
            ptr_d = ptr_q + PTR_W'(1);
        end
        flows_d = complete ? {bus.input_blocks, bank_q} : flows_q;
        valid_d = complete || (valid_q && !bus.i_ready);
        rcnt_d  = discard ? '0 : complete ? ((rcnt_q == RMAX) ? '0 : rcnt_q + CNT_W'(1)) : rcnt_q;
        cnt_d   = complete ? rcnt_q : cnt_q;
        am_d    = complete ? (rcnt_q == '0) : am_q;
        perr_d  = discard;
    end

    // State registers, cleared asynchronously so a reset mid-round drops collected blocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            bank_q  <= '0;
            flows_q <= '0;
            valid_q <= 1'b0;
            rcnt_q  <= '0;
            cnt_q   <= '0;
            am_q    <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            bank_q  <= bank_d;
            flows_q <= flows_d;
            valid_q <= valid_d;
            rcnt_q  <= rcnt_d;
            cnt_q   <= cnt_d;
            am_q    <= am_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.o_ready       = ready;
    assign bus.flows         = flows_q;
    assign bus.valid         = valid_q;
    assign bus.o_round_cnt   = cnt_q;
    assign bus.o_am_round    = am_q;
    assign bus.o_partial_err = perr_q;
endmodule

// File: tb/tb_flow_distributor_n.sv
// tb_flow_distributor_n: directed checks of two distributor configurations (2 flows, and 4 flows with a 3-round AM period)
module tb_flow_distributor_n;
    localparam int BB = 257;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    flow_distributor_n_if #(.BITS_BLOCK(BB), .NUM_FLOWS(2), .CNT_W(12)) a ();
    flow_distributor_n_if #(.BITS_BLOCK(BB), .NUM_FLOWS(4), .CNT_W(2))  b ();

    flow_distributor_n #(.BITS_BLOCK(BB), .NUM_FLOWS(2), .ROUNDS_PER_AM(4096)) ua (.clk(clk), .rst(rst), .bus(a));
    flow_distributor_n #(.BITS_BLOCK(BB), .NUM_FLOWS(4), .ROUNDS_PER_AM(3))    ub (.clk(clk), .rst(rst), .bus(b));

    function automatic logic [BB-1:0] blk(input int n);
        logic [31:0] w;
        w = 32'(n) ^ 32'hA5A5_0000;
        return {w[0], {8{w}}};
    endfunction

    task automatic chk(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input int n, input logic s);
        a.i_valid = 1'b1;
        a.i_sync = s;
        a.input_blocks = blk(n);
    endtask

    task automatic put_b(input int n, input logic s);
        b.i_valid = 1'b1;
        b.i_sync = s;
        b.input_blocks = blk(n);
    endtask

    initial begin
        a.i_valid = 1'b0; a.i_sync = 1'b0; a.input_blocks = '0; a.i_ready = 1'b1;
        b.i_valid = 1'b0; b.i_sync = 1'b0; b.input_blocks = '0; b.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", BB'(a.valid), BB'(0));
        chk("rst_a_flows", a.flows[BB-1:0], '0);
        chk("rst_a_ready", BB'(a.o_ready), BB'(1));
        chk("rst_b_valid", BB'(b.valid), BB'(0));
        chk("rst_b_cnt", BB'(b.o_round_cnt), BB'(0));
        chk("rst_b_perr", BB'(b.o_partial_err), BB'(0));
        rst = 1'b1;
        tick();

        // Two-flow stream A,B,C,D
        put_a(1, 1'b0); tick();
        chk("a_valid_after_A", BB'(a.valid), BB'(0));
        put_a(2, 1'b0); tick();
        chk("a_valid_r0", BB'(a.valid), BB'(1));
        chk("a_f0_r0", a.flows[0 +: BB], blk(1));
        chk("a_f1_r0", a.flows[BB +: BB], blk(2));
        chk("a_cnt_r0", BB'(a.o_round_cnt), BB'(0));
        chk("a_am_r0", BB'(a.o_am_round), BB'(1));
        put_a(3, 1'b0); tick();
        chk("a_valid_after_C", BB'(a.valid), BB'(0));
        put_a(4, 1'b0); tick();
        chk("a_valid_r1", BB'(a.valid), BB'(1));
        chk("a_f0_r1", a.flows[0 +: BB], blk(3));
        chk("a_f1_r1", a.flows[BB +: BB], blk(4));
        chk("a_cnt_r1", BB'(a.o_round_cnt), BB'(1));
        chk("a_am_r1", BB'(a.o_am_round), BB'(0));
        a.i_valid = 1'b0; tick();
        chk("a_drain", BB'(a.valid), BB'(0));

        // Ten back-to-back four-flow rounds, AM period of 3
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                put_b(100 + r * 4 + k, 1'b0); tick();
            end
            chk($sformatf("b_cnt_%0d", r), BB'(b.o_round_cnt), BB'(r % 3));
            chk($sformatf("b_am_%0d", r), BB'(b.o_am_round), BB'(r % 3 == 0));
            chk($sformatf("b_f0_%0d", r), b.flows[0 +: BB], blk(100 + r * 4));
            chk($sformatf("b_f3_%0d", r), b.flows[3*BB +: BB], blk(103 + r * 4));
        end

        // Backpressure: round completes, then downstream stalls
        for (int k = 0; k < 4; k++) begin
            put_b(200 + k, 1'b0); tick();
        end
        chk("bp_cnt_first", BB'(b.o_round_cnt), BB'(1));
        b.i_ready = 1'b0;
        for (int k = 4; k < 7; k++) begin
            put_b(200 + k, 1'b0); #1;
            chk($sformatf("bp_ready_%0d", k), BB'(b.o_ready), BB'(1));
            tick();
            chk($sformatf("bp_valid_%0d", k), BB'(b.valid), BB'(1));
            chk($sformatf("bp_f0_%0d", k), b.flows[0 +: BB], blk(200));
        end
        put_b(207, 1'b0); #1;
        chk("bp_ready_low", BB'(b.o_ready), BB'(0));
        tick();
        chk("bp_hold_f3", b.flows[3*BB +: BB], blk(203));
        chk("bp_hold_cnt", BB'(b.o_round_cnt), BB'(1));
        chk("bp_ready_low2", BB'(b.o_ready), BB'(0));
        b.i_ready = 1'b1; #1;
        chk("bp_ready_release", BB'(b.o_ready), BB'(1));
        tick();
        chk("bp_valid_cont", BB'(b.valid), BB'(1));
        chk("bp_f0_r2", b.flows[0 +: BB], blk(204));
        chk("bp_f3_r2", b.flows[3*BB +: BB], blk(207));
        chk("bp_cnt_r2", BB'(b.o_round_cnt), BB'(2));
        b.i_valid = 1'b0; tick();
        chk("bp_drain", BB'(b.valid), BB'(0));

        // One round to move the counter off zero
        for (int k = 0; k < 4; k++) begin
            put_b(400 + k, 1'b0); tick();
        end
        chk("pre_sync_cnt", BB'(b.o_round_cnt), BB'(0));

        // Sync strobe mid-round discards the partial round
        put_b(300, 1'b0); tick();
        put_b(301, 1'b0); tick();
        chk("sync_no_err_yet", BB'(b.o_partial_err), BB'(0));
        put_b(302, 1'b1); tick();
        chk("sync_perr_pulse", BB'(b.o_partial_err), BB'(1));
        put_b(303, 1'b0); tick();
        chk("sync_perr_clear", BB'(b.o_partial_err), BB'(0));
        put_b(304, 1'b0); tick();
        put_b(305, 1'b0); tick();
        chk("sync_valid", BB'(b.valid), BB'(1));
        chk("sync_f0", b.flows[0 +: BB], blk(302));
        chk("sync_f1", b.flows[BB +: BB], blk(303));
        chk("sync_f3", b.flows[3*BB +: BB], blk(305));
        chk("sync_cnt", BB'(b.o_round_cnt), BB'(0));
        chk("sync_am", BB'(b.o_am_round), BB'(1));

        // Sync strobe on a round boundary
        put_b(500, 1'b1); tick();
        chk("bnd_no_err", BB'(b.o_partial_err), BB'(0));
        put_b(501, 1'b0); tick();
        put_b(502, 1'b0); tick();
        put_b(503, 1'b0); tick();
        chk("bnd_f0", b.flows[0 +: BB], blk(500));
        chk("bnd_cnt", BB'(b.o_round_cnt), BB'(1));
        chk("bnd_am", BB'(b.o_am_round), BB'(0));
        b.i_valid = 1'b0; b.i_sync = 1'b0;

        // Asynchronous reset mid-round with a held output
        put_a(600, 1'b0); tick();
        put_a(601, 1'b0); tick();
        a.i_ready = 1'b0;
        put_a(602, 1'b0); tick();
        a.i_valid = 1'b0;
        chk("pre_rst_valid", BB'(a.valid), BB'(1));
        chk("pre_rst_cnt", BB'(a.o_round_cnt), BB'(2));
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", BB'(a.valid), BB'(0));
        chk("arst_f0", a.flows[0 +: BB], '0);
        chk("arst_cnt", BB'(a.o_round_cnt), BB'(0));
        chk("arst_am", BB'(a.o_am_round), BB'(0));
        #1 rst = 1'b1;
        a.i_ready = 1'b1;
        tick();
        put_a(603, 1'b0); tick();
        chk("post_rst_no_valid", BB'(a.valid), BB'(0));
        put_a(604, 1'b0); tick();
        chk("post_rst_valid", BB'(a.valid), BB'(1));
        chk("post_rst_f0", a.flows[0 +: BB], blk(603));
        chk("post_rst_f1", a.flows[BB +: BB], blk(604));
        chk("post_rst_cnt", BB'(a.o_round_cnt), BB'(0));
        chk("post_rst_am", BB'(a.o_am_round), BB'(1));
        a.i_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
